subpel_interp_ctrl: RTL and testbench

//  Sequencer for the 8x8 subpixel interpolation datapath; replaces its free-running counter and comparator decodes.
//  Per block:
//   - fetch BLK+TAPS-1 rows into the input shift register (row_req/row_ack handshake);
//   - run a horizontal pass over all buffered rows, then a vertical pass over the half-pel feedback buffer;
//   - generate the shift, mux-select and output-filler write enables, each aligned to the FIR pipeline latency.

---
 rtl/subpel_interp_ctrl.sv | 179 +++++++++++++++++
 tb/tb_subpel_interp_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/subpel_interp_ctrl.sv
// Sequencer for the 8x8 subpixel interpolation datapath: fetches reference
// rows, issues horizontal then vertical FIR passes, and times the shift,
// half-pel feedback and output-filler strobes to the FIR pipeline latency.
module subpel_interp_ctrl #(
    parameter int unsigned BLK     = 8,
    parameter int unsigned TAPS    = 8,
    parameter int unsigned FIR_LAT = 2,
    parameter int unsigned IDXW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            row_req,
    output logic [IDXW-1:0] row_idx,
    input  logic            row_ack,
    output logic            in_shift,
    output logic [IDXW-1:0] mux_sel,
    output logic            hsr_load,
    output logic            out_we,
    output logic [IDXW-1:0] out_row,
    output logic            busy,
    output logic            done
);

    localparam int unsigned     NROWS      = BLK + TAPS - 1;
    localparam logic [IDXW-1:0] ONE        = IDXW'(1);
    localparam logic [IDXW-1:0] LAST_ROW   = IDXW'(NROWS - 1);
    localparam logic [IDXW-1:0] LAST_V     = IDXW'(BLK - 1);
    localparam logic [IDXW-1:0] LAST_DRAIN = IDXW'(FIR_LAT - 1);
    localparam logic [IDXW-2:0] H_LO       = (IDXW-1)'(TAPS / 2 - 1);
    localparam logic [IDXW-2:0] H_HI       = (IDXW-1)'(TAPS / 2 + BLK - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HPASS,
        S_VPASS,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [IDXW-1:0]                cnt_q, cnt_d;
    logic [IDXW-1:0]                sel_q, sel_d;
    logic [FIR_LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [FIR_LAT-1:0][IDXW-1:0]   tag_q, tag_d;

    logic            issue;
    logic [IDXW-1:0] issue_tag;
    logic            t_vld;
    logic            t_kind;
    logic [IDXW-2:0] t_idx;

    // State, shared row/issue/drain counter, held mux select and tag delay line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            tag_vld_q <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
        end
    end

    // Next-state, fetch handshake, issue tags and delay-line advance
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        issue     = 1'b0;
        issue_tag = '0;
        row_req   = 1'b0;
        row_idx   = '0;
        in_shift  = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                row_req  = 1'b1;
                row_idx  = cnt_q;
                in_shift = row_ack;
                if (row_ack) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_HPASS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_HPASS: begin
                issue     = 1'b1;
                issue_tag = {1'b0, cnt_q[IDXW-2:0]};
                if (cnt_q == LAST_ROW) begin
                    state_d = S_VPASS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_VPASS: begin
                issue     = 1'b1;
                issue_tag = {1'b1, cnt_q[IDXW-2:0]};
                if (cnt_q == LAST_V) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (issue) begin
            sel_d = issue_tag;
        end
        mux_sel = sel_d;

        tag_vld_d[0] = issue;
        tag_d[0]     = issue_tag;
        for (int unsigned i = 1; i < FIR_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_d[i]     = tag_q[i-1];
        end

        // abort overrides everything, including a same-cycle start in IDLE
        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            tag_vld_d = '0;
        end
    end

    // Strobes decoded from the tag leaving the delay line
    always_comb begin
        t_vld    = tag_vld_q[FIR_LAT-1];
        t_kind   = tag_q[FIR_LAT-1][IDXW-1];
        t_idx    = tag_q[FIR_LAT-1][IDXW-2:0];
        hsr_load = t_vld & ~t_kind;
        out_we   = 1'b0;
        out_row  = '0;
        if (t_vld && t_kind) begin
            out_we  = 1'b1;
            out_row = IDXW'(BLK) + {1'b0, t_idx};
        end else if (t_vld && (t_idx >= H_LO) && (t_idx <= H_HI)) begin
            out_we  = 1'b1;
            out_row = {1'b0, t_idx - H_LO};
        end
    end

endmodule

// File: tb/tb_subpel_interp_ctrl.sv
// Self-checking bench for subpel_interp_ctrl: a timeline model predicts every
// output each cycle, and directed scenarios pin key cycle numbers literally.
module tb_subpel_interp_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, row_ack;
    logic       row_req, in_shift, hsr_load, out_we, busy, done;
    logic [7:0] row_idx, mux_sel, out_row;

    subpel_interp_ctrl #(.BLK(8), .TAPS(8), .FIR_LAT(2), .IDXW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .row_req(row_req), .row_idx(row_idx), .row_ack(row_ack),
        .in_shift(in_shift), .mux_sel(mux_sel), .hsr_load(hsr_load),
        .out_we(out_we), .out_row(out_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Timeline model: a block is fetch (15 acked rows) followed by k=1..26
    // where k 1..15 issue H rows, 16..23 issue V rows, strobes land 2 cycles
    // after issue, and k=26 is the done cycle.
    bit         sch_h [0:4095];
    bit         sch_w [0:4095];
    int         sch_r [0:4095];
    bit         m_act = 0;
    int         m_acks = 0;
    int         m_k = 0;
    logic [7:0] m_last_sel = '0;

    // Tallies for the literal checks, cleared on request from the stimulus
    int clr_gen = 0, clr_seen = 0;
    int n_shift, last_shift, n_hsr, first_hsr, last_hsr;
    int n_we, first_we, last_we, last_row, n_done, done_at;
    int we_rows[$];
    int shift_idx[$];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            sch_h[i] = 0; sch_w[i] = 0; sch_r[i] = 0;
        end
    end

    always @(negedge clk) begin
        bit         fetching, issuing;
        bit         e_req, e_shift, e_hsr, e_we, e_busy, e_done;
        int         e_ridx, e_row, idx;
        logic [7:0] e_sel;

        if (clr_gen != clr_seen) begin
            clr_seen = clr_gen;
            n_shift = 0; last_shift = -1; n_hsr = 0; first_hsr = -1; last_hsr = -1;
            n_we = 0; first_we = -1; last_we = -1; last_row = -1; n_done = 0; done_at = -1;
            we_rows.delete(); shift_idx.delete();
        end

        fetching = m_act && (m_acks < 15);
        issuing  = m_act && (m_k >= 1) && (m_k <= 23);
        e_sel    = m_last_sel;
        if (issuing) e_sel = (m_k <= 15) ? 8'(m_k - 1) : 8'(128 + m_k - 16);

        if (!rst) begin
            e_req = 0; e_ridx = 0; e_shift = 0; e_sel = '0; e_hsr = 0;
            e_we = 0; e_row = 0; e_busy = 0; e_done = 0;
        end else begin
            e_req   = fetching;
            e_ridx  = fetching ? m_acks : 0;
            e_shift = fetching && row_ack;
            e_hsr   = sch_h[cyc];
            e_we    = sch_w[cyc];
            e_row   = sch_r[cyc];
            e_busy  = m_act;
            e_done  = m_act && (m_k == 26);
        end

        check("row_req", row_req, e_req);
        check("row_idx", row_idx, e_ridx);
        check("in_shift", in_shift, e_shift);
        check("mux_sel", mux_sel, e_sel);
        check("hsr_load", hsr_load, e_hsr);
        check("out_we", out_we, e_we);
        check("out_row", out_row, e_row);
        check("busy", busy, e_busy);
        check("done", done, e_done);

        if (in_shift) begin n_shift++; last_shift = cyc; shift_idx.push_back(int'(row_idx)); end
        if (hsr_load) begin n_hsr++; if (first_hsr < 0) first_hsr = cyc; last_hsr = cyc; end
        if (out_we) begin
            n_we++; if (first_we < 0) first_we = cyc; last_we = cyc;
            last_row = int'(out_row); we_rows.push_back(int'(out_row));
        end
        if (done) begin n_done++; done_at = cyc; end

        if (!rst) begin
            m_act = 0; m_last_sel = '0;
            sch_h[cyc+1] = 0; sch_w[cyc+1] = 0; sch_r[cyc+1] = 0;
            sch_h[cyc+2] = 0; sch_w[cyc+2] = 0; sch_r[cyc+2] = 0;
        end else if (abort) begin
            if (issuing) m_last_sel = e_sel;
            m_act = 0;
            sch_h[cyc+1] = 0; sch_w[cyc+1] = 0; sch_r[cyc+1] = 0;
            sch_h[cyc+2] = 0; sch_w[cyc+2] = 0; sch_r[cyc+2] = 0;
        end else begin
            if (issuing) begin
                m_last_sel = e_sel;
                if (m_k <= 15) begin
                    idx = m_k - 1;
                    sch_h[cyc+2] = 1;
                    if (idx >= 3 && idx <= 10) begin
                        sch_w[cyc+2] = 1; sch_r[cyc+2] = idx - 3;
                    end
                end else begin
                    idx = m_k - 16;
                    sch_w[cyc+2] = 1; sch_r[cyc+2] = 8 + idx;
                end
            end
            if (!m_act) begin
                if (start) begin m_act = 1; m_acks = 0; m_k = 0; end
            end else if (fetching) begin
                if (row_ack) begin
                    m_acks++;
                    if (m_acks == 15) m_k = 1;
                end
            end else if (m_k == 26) begin
                m_act = 0;
            end else begin
                m_k++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    int t0, t1;

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; row_ack = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_mux_sel", mux_sel, 0);
        check("rst_out_we", out_we, 0);
        rst = 1'b1;
        step();

        // Reset in the middle of LOAD, then a fresh block refetches from row 0
        row_ack = 1'b1; start = 1'b1; t0 = cyc; step(); start = 1'b0;
        run_to(t0 + 6);
        check("t1_row_idx5", row_idx, 5);
        rst = 1'b0;
        #1;
        check("t1_rst_req", row_req, 0);
        check("t1_rst_idx", row_idx, 0);
        check("t1_rst_busy", busy, 0);
        step(); step();
        rst = 1'b1;
        step();

        // Full block with row_ack tied high
        clr_gen++;
        start = 1'b1; t0 = cyc; step(); start = 1'b0;
        check("t2_first_idx", row_idx, 0);
        run_to(t0 + 45);
        check("t2_n_shift", n_shift, 15);
        check("t2_first_hsr", first_hsr - t0, 18);
        check("t2_last_hsr", last_hsr - t0, 32);
        check("t2_n_hsr", n_hsr, 15);
        check("t2_first_we", first_we - t0, 21);
        check("t2_last_we", last_we - t0, 40);
        check("t2_n_we", n_we, 16);
        check("t2_done_at", done_at - t0, 41);
        check("t2_n_done", n_done, 1);
        if (we_rows.size() == 16) begin
            check("t2_row_at_28", we_rows[7], 7);
            check("t2_row_at_33", we_rows[8], 8);
        end else begin
            check("t2_we_rows_size", we_rows.size(), 16);
        end

        // row_ack low on alternate cycles
        clr_gen++;
        row_ack = 1'b0; start = 1'b1; t0 = cyc; step(); start = 1'b0;
        while (cyc < t0 + 80) begin
            row_ack = ~row_ack;
            step();
        end
        row_ack = 1'b1;
        check("t3_n_shift", n_shift, 15);
        check("t3_hpass_start", first_hsr - last_shift, 3);
        check("t3_done_at", done_at - last_shift, 26);
        check("t3_n_done", n_done, 1);
        for (int i = 0; i < shift_idx.size(); i++) check("t3_row_order", shift_idx[i], i);

        // abort during VPASS at idx 3
        clr_gen++;
        start = 1'b1; t0 = cyc; step(); start = 1'b0;
        run_to(t0 + 34);
        check("t4_vidx3", mux_sel, 8'h83);
        abort = 1'b1; step(); abort = 1'b0;
        check("t4_busy_after", busy, 0);
        run_to(t0 + 50);
        check("t4_n_we", n_we, 10);
        check("t4_last_we", last_we - t0, 34);
        check("t4_last_row", last_row, 9);
        check("t4_n_done", n_done, 0);

        // start during HPASS and row_ack in IDLE are ignored
        clr_gen++;
        row_ack = 1'b1; step();
        start = 1'b1; t0 = cyc; step(); start = 1'b0;
        run_to(t0 + 20);
        start = 1'b1; step(); start = 1'b0;
        run_to(t0 + 50);
        check("t5_n_shift", n_shift, 15);
        check("t5_n_done", n_done, 1);
        check("t5_done_at", done_at - t0, 41);
        check("t5_n_we", n_we, 16);
        for (int i = 0; i < we_rows.size(); i++) check("t5_row_seq", we_rows[i], i);

        // start with abort in IDLE, then back-to-back blocks
        clr_gen++;
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check("t6_busy_abort", busy, 0);
        step();
        start = 1'b1; t0 = cyc; step(); start = 1'b0;
        run_to(t0 + 42);
        start = 1'b1; t1 = cyc; step(); start = 1'b0;
        run_to(t1 + 45);
        check("t6_done0_gap", t1 - t0, 42);
        check("t6_done_at", done_at - t1, 41);
        check("t6_n_done", n_done, 2);
        check("t6_n_we", n_we, 32);
        check("t6_n_shift", n_shift, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
